gate_truth_checker: RTL and testbench
=====================================

# gate_truth_checker

Synthesizable, self-checking exhaustive tester for any 2-input combinational gate. It drives the four input combinations into a gate DUT, samples the DUT output after a programmable settle time, compares each sample against a parameterised truth table and reports pass/fail with the first failing vector. It sits beside a lab gate module (and/or/xor, etc.) on the board or in simulation, replacing a hand-written stimulus/monitor bench with hardware.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before `dut_op` is sampled; legal range 1..255.
- `TRUTH_TABLE`, default 4'b1000: expected output per vector index k (bit k); 4'b1000 = AND, 4'b1110 = OR, 4'b0110 = XOR.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: begin a run; sampled on rising edge.
- `dut_op`  in  1: output of gate under test.
- `input1`  out  1: DUT input A; registered.
- `input2`  out  1: DUT input B; registered.
- `busy`  out  1: run in progress.
- `done`  out  1: run complete; results valid; holds until next accepted `start`.
- `pass`  out  1: high only when `done`=1 and `err_count`=0.
- `err_count`  out  3: number of mismatching vectors, 0..4.
- `fail_valid`  out  1: at least one mismatch seen this run.
- `fail_vec`  out  2: index k of first mismatching vector; valid when `fail_valid`=1.

## Operation
- Vector order k=0..3: {input2,input1} = k, i.e. (input1,input2) = (0,0),(1,0),(0,1),(1,1); expected = TRUTH_TABLE[k].
- States: IDLE, RUN, DONE.
- IDLE/DONE, `start`=1: clear `err_count`, `fail_valid`, `fail_vec`, `done`, `pass`; k=0; drive vector 0; settle counter=0; `busy`=1; -> RUN.
- RUN: settle counter increments each cycle; when counter reaches SETTLE_CYCLES-1, the next edge is a sample edge: compare `dut_op` against TRUTH_TABLE[k].
  - Mismatch: `err_count`+1; if `fail_valid`=0, set `fail_valid`=1 and `fail_vec`=k.
  - k<3: k+1, drive next vector, counter=0, stay RUN.
  - k=3: -> DONE; `busy`=0, `done`=1, `pass`=(final err_count==0); `input1`/`input2` return to 0.
- RUN, `start`=1: ignored.
- DONE: results held; `start` restarts as from IDLE.
- `err_count` cannot exceed 4; no saturation logic needed, but width is 3 bits.

## Timing
- Reset (asynchronous assert, any state, including mid-run): state=IDLE; `input1`=0, `input2`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_valid`=0, `fail_vec`=0. Deassertion is synchronous to `clk` in the integrating design.
- `start` accepted at edge E: vector 0 visible and `busy`=1 after E.
- Vector k driven from edge E+k·S (S=SETTLE_CYCLES); sampled at edge E+(k+1)·S, same edge drives vector k+1.
- `done`=1, `busy`=0 after edge E+4·S; total run latency 4·S cycles.
- S=1: each vector held one cycle; DUT must be purely combinational.
- `dut_op` is sampled only at sample edges; glitches between them are ignored.
- `pass` and `done` change on the same edge; `pass` never high while `busy`.

## Test plan
- Correct AND DUT, S=2, `start` pulse at edge 0 -> vectors 00,10,01,11 at edges 0/2/4/6; `done`=1, `pass`=1, `err_count`=0, `fail_valid`=0 after edge 8.
- `dut_op` stuck-at-0, TRUTH_TABLE=4'b1000 -> `err_count`=1, `fail_vec`=3, `fail_valid`=1, `pass`=0.
- `dut_op` stuck-at-1, TRUTH_TABLE=4'b1000 -> `err_count`=3, `fail_vec`=0, `pass`=0.
- `start` held high during RUN -> no restart; `done` still at edge 8; then second `start` in DONE clears results and reruns to `pass`=1.
- `rst_n` low at edge 5 mid-run -> all outputs 0 immediately; new `start` produces a clean full run.
- TRUTH_TABLE=4'b0110 with XOR DUT, S=1 -> `done` after edge 4, `pass`=1; same with AND DUT -> `err_count`=3, `fail_vec`=1.

Source files
------------

// File: rtl/gate_truth_checker.sv
// Exhaustive tester for a 2-input combinational gate: steps through the four
// input vectors, samples the gate after a settle time and scores it against TRUTH_TABLE.
module gate_truth_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  TRUTH_TABLE   = 4'b1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_op,
  output logic       input1,
  output logic       input2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic       fail_valid,
  output logic [1:0] fail_vec
);

  // Last settle count before a sample edge; SETTLE_CYCLES is 1..255.
  localparam logic [7:0] SAMPLE_CNT = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] k_q, k_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] err_q, err_d;
  logic       fv_q, fv_d;
  logic [1:0] fvec_q, fvec_d;
  logic       in1_q, in1_d;
  logic       in2_q, in2_d;
  logic       pass_q, pass_d;

  logic       sample;
  logic       mism;
  logic [1:0] k_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= 2'd0;
      cnt_q   <= 8'd0;
      err_q   <= 3'd0;
      fv_q    <= 1'b0;
      fvec_q  <= 2'd0;
      in1_q   <= 1'b0;
      in2_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fvec_d  = fvec_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    pass_d  = pass_q;
    sample  = 1'b0;
    mism    = 1'b0;
    k_next  = k_q + 2'd1;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          k_d     = 2'd0;
          cnt_d   = 8'd0;
          err_d   = 3'd0;
          fv_d    = 1'b0;
          fvec_d  = 2'd0;
          in1_d   = 1'b0;
          in2_d   = 1'b0;
          pass_d  = 1'b0;
        end
      end

      ST_RUN: begin
        sample = (cnt_q == SAMPLE_CNT);
        if (!sample) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          mism  = (dut_op != TRUTH_TABLE[k_q]);
          err_d = err_q + {2'b00, mism};
          if (mism && !fv_q) begin
            fv_d   = 1'b1;
            fvec_d = k_q;
          end
          if (k_q == 2'd3) begin
            state_d = ST_DONE;
            in1_d   = 1'b0;
            in2_d   = 1'b0;
            pass_d  = (err_d == 3'd0);
          end else begin
            // Vector index maps to {input2,input1}.
            k_d   = k_next;
            cnt_d = 8'd0;
            in1_d = k_next[0];
            in2_d = k_next[1];
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign input1     = in1_q;
  assign input2     = in2_q;
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: an AND-table instance at S=2 and an
// XOR-table instance at S=1, each driving a selectable behavioural gate.
module tb_gate_truth_checker;

  localparam int MODE_AND = 0;
  localparam int MODE_SA0 = 1;
  localparam int MODE_SA1 = 2;
  localparam int MODE_XOR = 3;

  logic clk;
  logic rst_n;

  logic       start_a, dut_op_a, in1_a, in2_a, busy_a, done_a, pass_a, fv_a;
  logic [2:0] err_a;
  logic [1:0] fvec_a;
  int         mode_a;

  logic       start_b, dut_op_b, in1_b, in2_b, busy_b, done_b, pass_b, fv_b;
  logic [2:0] err_b;
  logic [1:0] fvec_b;
  int         mode_b;

  int n_checks;
  int n_fail;

  gate_truth_checker #(.SETTLE_CYCLES(2), .TRUTH_TABLE(4'b1000)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_op(dut_op_a),
    .input1(in1_a), .input2(in2_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .fail_valid(fv_a), .fail_vec(fvec_a)
  );

  gate_truth_checker #(.SETTLE_CYCLES(1), .TRUTH_TABLE(4'b0110)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_op(dut_op_b),
    .input1(in1_b), .input2(in2_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .fail_valid(fv_b), .fail_vec(fvec_b)
  );

  function automatic logic gate(input int mode, input logic a, input logic b);
    case (mode)
      MODE_AND: return a & b;
      MODE_SA0: return 1'b0;
      MODE_SA1: return 1'b1;
      default:  return a ^ b;
    endcase
  endfunction

  assign dut_op_a = gate(mode_a, in1_a, in2_a);
  assign dut_op_b = gate(mode_b, in1_b, in2_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse start for one edge on instance A; returns just after the accept edge E.
  task automatic start_a_pulse();
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
  endtask

  task automatic start_b_pulse();
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
  endtask

  task automatic check_results_a(input string tag, input int d, input int p,
                                 input int e, input int fv, input int fvec);
    check({tag, ".done"}, done_a, d);
    check({tag, ".busy"}, busy_a, 0);
    check({tag, ".pass"}, pass_a, p);
    check({tag, ".err"}, err_a, e);
    check({tag, ".fv"}, fv_a, fv);
    if (fv != 0) check({tag, ".fvec"}, fvec_a, fvec);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    mode_a   = MODE_AND;
    mode_b   = MODE_XOR;
    rst_n    = 1'b0;
    tick(2);

    check("rst.in1", in1_a, 0);
    check("rst.in2", in2_a, 0);
    check("rst.busy", busy_a, 0);
    check("rst.done", done_a, 0);
    check("rst.pass", pass_a, 0);
    check("rst.err", err_a, 0);
    check("rst.fv", fv_a, 0);
    check("rst.fvec", fvec_a, 0);

    @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    // Correct AND gate, S=2: vectors 00,10,01,11 at E, E+2, E+4, E+6
    start_a_pulse();
    check("and.busy0", busy_a, 1);
    check("and.v0", {in2_a, in1_a}, 2'b00);
    tick(1);
    check("and.v0hold", {in2_a, in1_a}, 2'b00);
    tick(1);
    check("and.v1", {in2_a, in1_a}, 2'b01);
    tick(2);
    check("and.v2", {in2_a, in1_a}, 2'b10);
    tick(2);
    check("and.v3", {in2_a, in1_a}, 2'b11);
    tick(1);
    check("and.busy7", busy_a, 1);
    check("and.done7", done_a, 0);
    check("and.pass7", pass_a, 0);
    tick(1);
    check_results_a("and", 1, 1, 0, 0, 0);
    check("and.in_idle", {in2_a, in1_a}, 2'b00);
    tick(3);
    check("and.hold", done_a, 1);

    // Stuck-at-0: only vector 3 mismatches
    mode_a = MODE_SA0;
    start_a_pulse();
    tick(8);
    check_results_a("sa0", 1, 0, 1, 1, 3);

    // Stuck-at-1: vectors 0,1,2 mismatch
    mode_a = MODE_SA1;
    start_a_pulse();
    tick(8);
    check_results_a("sa1", 1, 0, 3, 1, 0);

    // Start held through RUN: no restart, and the DONE results get cleared
    mode_a  = MODE_AND;
    start_a = 1'b1;
    tick(1);
    check("hold.busy", busy_a, 1);
    check("hold.err_clr", err_a, 0);
    check("hold.fv_clr", fv_a, 0);
    check("hold.fvec_clr", fvec_a, 0);
    check("hold.done_clr", done_a, 0);
    tick(4);
    check("hold.v2", {in2_a, in1_a}, 2'b10);
    tick(3);
    start_a = 1'b0;
    check("hold.busy7", busy_a, 1);
    tick(1);
    check_results_a("hold", 1, 1, 0, 0, 0);

    // Restart from DONE
    mode_a = MODE_SA0;
    start_a_pulse();
    tick(8);
    check_results_a("rerun_sa0", 1, 0, 1, 1, 3);
    mode_a = MODE_AND;
    start_a_pulse();
    check("rerun.pass_clr", pass_a, 0);
    tick(8);
    check_results_a("rerun", 1, 1, 0, 0, 0);

    // Asynchronous reset mid-run
    mode_a = MODE_SA1;
    start_a_pulse();
    tick(5);
    check("mid.err", err_a, 2);
    check("mid.fv", fv_a, 1);
    check("mid.v2", {in2_a, in1_a}, 2'b10);
    rst_n = 1'b0;
    #1;
    check("mid.busy", busy_a, 0);
    check("mid.in", {in2_a, in1_a}, 2'b00);
    check("mid.err0", err_a, 0);
    check("mid.fv0", fv_a, 0);
    check("mid.done0", done_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mode_a = MODE_AND;
    tick(1);
    start_a_pulse();
    tick(8);
    check_results_a("post_rst", 1, 1, 0, 0, 0);

    // XOR table, S=1
    mode_b = MODE_XOR;
    start_b_pulse();
    check("xor.v0", {in2_b, in1_b}, 2'b00);
    tick(1);
    check("xor.v1", {in2_b, in1_b}, 2'b01);
    tick(2);
    check("xor.done3", done_b, 0);
    check("xor.busy3", busy_b, 1);
    tick(1);
    check("xor.done", done_b, 1);
    check("xor.pass", pass_b, 1);
    check("xor.err", err_b, 0);

    mode_b = MODE_AND;
    start_b_pulse();
    tick(4);
    check("xand.done", done_b, 1);
    check("xand.pass", pass_b, 0);
    check("xand.err", err_b, 3);
    check("xand.fv", fv_b, 1);
    check("xand.fvec", fvec_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
